instr_register_exec: RTL and testbench
======================================

# instr_register_exec

Execution-side counterpart of the instruction register bench: accepts instruction writes (opcode plus two signed operands), computes the 64-bit result with a multi-cycle execute FSM, and stores `{opc, op_a, op_b, rezultat}` into a 32-entry register file. The register file is read back through `read_pointer` / `instruction_word`. The block sits between the instruction-register test driver and any downstream consumer of `instruction_word`. Write throughput is throttled by a `load_ready` handshake.

## Interface
- `DEPTH`, 32: register-file entries; address width is `$clog2(DEPTH)` = 5.
- `OP_W`, 32: operand width (signed).
- `RES_W`, 64: result width (signed).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_en`  in  1  write request; accepted only on a cycle where `load_ready`=1.
- `load_ready`  out  1  block idle and able to accept a write.
- `write_pointer`  in  5  destination entry; sampled at accept.
- `opcode`  in  4  opcode_t: ZERO=0, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, POW=8; sampled at accept.
- `operand_a`, `operand_b`  in  32  signed operands; sampled at accept.
- `read_pointer`  in  5  read address.
- `instruction_word`  out  132  instruction_t `{opc[3:0], op_a[31:0], op_b[31:0], rezultat[63:0]}` at `read_pointer`; combinational read.
- `read_valid`  out  1  entry at `read_pointer` has been written since reset.

## Operation
- FSM states:
  - IDLE: `load_ready`=1. On `load_en`, capture the inputs. Go to WRITE for ZERO/PASSA/PASSB/ADD/SUB/MULT and for opcodes 9–15; go to ITER for DIV/MOD/POW.
  - ITER: 32 iterations, one per cycle; then go to WRITE.
  - WRITE: commit the entry, set its valid bit, return to IDLE. `load_ready`=0 in ITER and WRITE.
- Arithmetic: operands are sign-extended to 64 bits.
  - ZERO → 0; PASSA → a; PASSB → b.
  - ADD/SUB → a±b in 64 bits.
  - MULT → exact 64-bit signed product, from one combinational multiplier shared with POW.
- DIV/MOD: restoring division on magnitudes, 1 quotient bit per cycle.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - b==0 → result 0 and skips ITER, going straight to WRITE.
- POW: square-and-multiply, scanning exponent bits MSB→LSB, one bit per cycle, all arithmetic mod 2^64.
  - b==0 → 1.
  - b<0 → 0 unless a==1 (→1) or a==−1 (→±1 per parity of b).
  - The b==0 and b<0 cases skip ITER.
- Opcodes 9–15: stored as given; result 0.
- A write to an already-valid entry overwrites it. The last commit wins.
- `load_en` while `load_ready`=0 is ignored. It is not queued.

## Timing
- Reset values (asserted at any clock edge, including mid-ITER):
  - All entries → all-zero.
  - All valid bits → 0.
  - FSM → IDLE, `load_ready`=1.
  - Any in-flight operation is discarded without a commit.
- Latency is counted from the accept edge to the commit edge:
  - 1 edge for simple ops, MULT, opcodes 9–15, and the DIV/MOD/POW shortcut cases.
  - 33 edges for DIV/MOD/POW that iterate.
- Committed data is visible on `instruction_word` in the cycle after the commit edge.
- Read of the same address during the commit cycle returns the old contents.
- Back-to-back accepts happen at most every 2 cycles for simple ops and every 34 for iterated ops.

## Configuration
- `INSTR_REG_DIV_EN` defined: DIV/MOD are implemented as above.
- Not defined: the divider is omitted. DIV/MOD take the 1-edge path and store result 0. All other opcodes are unchanged.

## Test plan
- Reset, then read every address → `instruction_word`=0, `read_valid`=0, `load_ready`=1.
- Write ADD a=−7, b=5 to entry 3 → `load_ready` low 1 cycle; entry 3 reads `{ADD, −7, 5, −2}`; `read_valid`=1.
- DIV a=−15, b=4 to entry 0, then MOD with the same operands to entry 1 → entry 0 result −3, entry 1 result −3; `load_ready` low 33 cycles each; `load_en` pulses during busy are ignored.
- POW a=3, b=5 → 243; POW a=−1, b=3 → −1; POW a=2, b=−1 → 0; DIV b=0 → 0 with 1-edge latency.
- Assert `reset` in the 10th ITER cycle of a DIV to entry 7 → entry 7 stays 0 with `read_valid`=0; the next ADD accepts immediately.
- Build without `INSTR_REG_DIV_EN`: DIV a=12, b=3 → result 0 with 1-edge latency; MULT a=−15, b=15 → −225.

Source files
------------

// File: rtl/instr_register_exec.sv
// Instruction execute/store block: multi-cycle execute FSM feeding a 32-entry register file.
// Define INSTR_REG_DIV_EN to build the restoring divider for DIV/MOD; otherwise they store 0.
module instr_register_exec #(
    parameter int DEPTH = 32,
    parameter int OP_W  = 32,
    parameter int RES_W = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_en,
    output logic                        load_ready,
    input  logic [$clog2(DEPTH)-1:0]    write_pointer,
    input  logic [3:0]                  opcode,
    input  logic signed [OP_W-1:0]      operand_a,
    input  logic signed [OP_W-1:0]      operand_b,
    input  logic [$clog2(DEPTH)-1:0]    read_pointer,
    output logic [4+2*OP_W+RES_W-1:0]   instruction_word,
    output logic                        read_valid,
    output logic [1:0]                  dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = 4 + 2*OP_W + RES_W;
    localparam int CW = $clog2(OP_W);

    typedef enum logic [3:0] {
        OPC_ZERO  = 4'd0,
        OPC_PASSA = 4'd1,
        OPC_PASSB = 4'd2,
        OPC_ADD   = 4'd3,
        OPC_SUB   = 4'd4,
        OPC_MULT  = 4'd5,
        OPC_DIV   = 4'd6,
        OPC_MOD   = 4'd7,
        OPC_POW   = 4'd8
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // Handshake: a write is accepted on a rising edge where load_en=1 and load_ready=1;
    // load_en while load_ready=0 is dropped, never queued.
    state_t           state_q, state_d;
    logic [3:0]       opc_q, opc_d;
    logic [OP_W-1:0]  a_q, a_d;
    logic [OP_W-1:0]  b_q, b_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [OP_W-1:0]  sh_q, sh_d;
    logic [IW-1:0]    mem_q [DEPTH];
    logic [IW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;

    logic             commit;
    logic             pow_iter;
    logic             div_iter;
    logic [RES_W-1:0] a_ext, b_ext;
    logic [RES_W-1:0] mul_x, mul_y, mul_p, pow_p;
    logic [RES_W-1:0] div_res, pow_res, res;

    assign a_ext = {{(RES_W-OP_W){a_q[OP_W-1]}}, a_q};
    assign b_ext = {{(RES_W-OP_W){b_q[OP_W-1]}}, b_q};

    // The squaring step of POW reuses the MULT multiplier; pow_p folds in the base.
    always_comb begin
        mul_x = a_ext;
        mul_y = b_ext;
        if (state_q == S_ITER) begin
            mul_x = acc_q;
            mul_y = acc_q;
        end
        mul_p = mul_x * mul_y;
        pow_p = mul_p * a_ext;
    end

    assign pow_iter = (opcode == OPC_POW) && !operand_b[OP_W-1] && (operand_b != '0);

`ifdef INSTR_REG_DIV_EN
    logic [OP_W-1:0]  rem_q, rem_d;
    logic [OP_W-1:0]  mag_a_in, mag_b;
    logic [OP_W:0]    rem_sh, trial;
    logic [RES_W-1:0] quo_ext, rem_ext;

    assign mag_a_in = operand_a[OP_W-1] ? -operand_a : operand_a;
    assign mag_b    = b_q[OP_W-1] ? -b_q : b_q;
    assign rem_sh   = {rem_q, sh_q[OP_W-1]};
    assign trial    = rem_sh - {1'b0, mag_b};
    assign div_iter = ((opcode == OPC_DIV) || (opcode == OPC_MOD)) && (operand_b != '0);

    always_comb begin
        quo_ext = {{(RES_W-OP_W){1'b0}}, sh_q};
        rem_ext = {{(RES_W-OP_W){1'b0}}, rem_q};
        if (a_q[OP_W-1] ^ b_q[OP_W-1]) quo_ext = -quo_ext;
        if (a_q[OP_W-1])               rem_ext = -rem_ext;
        div_res = '0;
        if (b_q != '0) div_res = (opc_q == OPC_MOD) ? rem_ext : quo_ext;
    end
`else
    assign div_iter = 1'b0;
    assign div_res  = '0;
`endif

    always_comb begin
        pow_res = acc_q;
        if (b_q == '0) begin
            pow_res = RES_W'(1);
        end else if (b_q[OP_W-1]) begin
            if (a_q == OP_W'(1))  pow_res = RES_W'(1);
            else if (a_q == '1)   pow_res = b_q[0] ? '1 : RES_W'(1);
            else                  pow_res = '0;
        end
    end

    always_comb begin
        res = '0;
        case (opc_q)
            OPC_ZERO:          res = '0;
            OPC_PASSA:         res = a_ext;
            OPC_PASSB:         res = b_ext;
            OPC_ADD:           res = a_ext + b_ext;
            OPC_SUB:           res = a_ext - b_ext;
            OPC_MULT:          res = mul_p;
            OPC_DIV, OPC_MOD:  res = div_res;
            OPC_POW:           res = pow_res;
            default:           res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        a_d        = a_q;
        b_d        = b_q;
        wptr_d     = wptr_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        sh_d       = sh_q;
`ifdef INSTR_REG_DIV_EN
        rem_d      = rem_q;
`endif
        load_ready = 1'b0;
        commit     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load_en) begin
                    opc_d  = opcode;
                    a_d    = operand_a;
                    b_d    = operand_b;
                    wptr_d = write_pointer;
                    cnt_d  = '0;
                    acc_d  = RES_W'(1);
                    sh_d   = operand_b;
`ifdef INSTR_REG_DIV_EN
                    rem_d  = '0;
                    if ((opcode == OPC_DIV) || (opcode == OPC_MOD)) sh_d = mag_a_in;
`endif
                    state_d = (pow_iter || div_iter) ? S_ITER : S_WRITE;
                end
            end
            S_ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (opc_q == OPC_POW) begin
                    // Exponent scanned MSB first: square, then multiply by the base on a 1 bit.
                    acc_d = sh_q[OP_W-1] ? pow_p : mul_p;
                    sh_d  = {sh_q[OP_W-2:0], 1'b0};
                end
`ifdef INSTR_REG_DIV_EN
                else begin
                    // Dividend bits shift out of sh_q as quotient bits shift in.
                    rem_d = trial[OP_W] ? rem_sh[OP_W-1:0] : trial[OP_W-1:0];
                    sh_d  = {sh_q[OP_W-2:0], ~trial[OP_W]};
                end
`endif
                if (cnt_q == CW'(OP_W-1)) state_d = S_WRITE;
            end
            S_WRITE: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (commit) begin
            mem_d[wptr_q]   = {opc_q, a_q, b_q, res};
            valid_d[wptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
`ifdef INSTR_REG_DIV_EN
            rem_q   <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
`ifdef INSTR_REG_DIV_EN
            rem_q   <= rem_d;
`endif
            mem_q   <= mem_d;
            valid_q <= valid_d;
        end
    end

    assign instruction_word = mem_q[read_pointer];
    assign read_valid       = valid_q[read_pointer];
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_instr_register_exec.sv
// Bench for instr_register_exec: directed and random writes checked against a behavioural model.
module tb_instr_register_exec;
    localparam int DEPTH = 32;
    localparam int IW    = 132;
`ifdef INSTR_REG_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic          load_ready;
    logic [4:0]    write_pointer;
    logic [3:0]    opcode;
    logic [31:0]   operand_a;
    logic [31:0]   operand_b;
    logic [4:0]    read_pointer;
    logic [IW-1:0] instruction_word;
    logic          read_valid;
    logic [1:0]    dbg_state;

    instr_register_exec dut (
        .clk              (clk),
        .reset            (reset),
        .load_en          (load_en),
        .load_ready       (load_ready),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .read_valid       (read_valid),
        .dbg_state        (dbg_state)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] model_mem [DEPTH];
    logic          model_valid [DEPTH];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_iter(input logic [3:0] opc, input logic [31:0] b);
        if (opc == 4'd8) return ($signed(b) > 0);
        if (opc == 4'd6 || opc == 4'd7) return DIV_EN && (b != 0);
        return 1'b0;
    endfunction

    function automatic logic [63:0] ref_res(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r, base;
        int unsigned e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (opc)
            4'd0: return 64'd0;
            4'd1: return sa;
            4'd2: return sb;
            4'd3: return sa + sb;
            4'd4: return sa - sb;
            4'd5: return sa * sb;
            4'd6: return (DIV_EN && sb != 0) ? sa / sb : 64'd0;
            4'd7: return (DIV_EN && sb != 0) ? sa % sb : 64'd0;
            4'd8: begin
                if (sb == 0) return 64'd1;
                if (sb < 0) begin
                    if (sa == 1) return 64'd1;
                    if (sa == -1) return ((sb & 1) != 0) ? -64'sd1 : 64'd1;
                    return 64'd0;
                end
                r = 1;
                base = sa;
                e = b;
                while (e != 0) begin
                    if (e[0]) r = r * base;
                    base = base * base;
                    e = e >> 1;
                end
                return r;
            end
            default: return 64'd0;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic accept(input logic [4:0] wp, input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        while (!load_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("ready_at_accept", IW'(load_ready), IW'(1));
        load_en       = 1'b1;
        write_pointer = wp;
        opcode        = opc;
        operand_a     = a;
        operand_b     = b;
        @(posedge clk);
        @(negedge clk);
        load_en       = 1'b0;
        operand_a     = $urandom;
        operand_b     = $urandom;
    endtask

    task automatic finish_write(input logic [4:0] wp, input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        int            busy = 0;
        logic [IW-1:0] old_w;
        logic          old_v;
        old_w = model_mem[wp];
        old_v = model_valid[wp];
        read_pointer = wp;
        while (!load_ready && busy < 200) begin
            #1;
            check("busy_old_word", instruction_word, old_w);
            check("busy_old_valid", IW'(read_valid), IW'(old_v));
            busy++;
            if ($urandom_range(0, 3) == 0) begin
                load_en       = 1'b1;
                write_pointer = 5'($urandom);
                opcode        = 4'($urandom);
                operand_a     = $urandom;
                operand_b     = $urandom;
            end else begin
                load_en = 1'b0;
            end
            @(negedge clk);
        end
        load_en = 1'b0;
        check("busy_cycles", IW'(busy), IW'(is_iter(opc, b) ? 33 : 1));
        model_mem[wp]   = {opc, a, b, ref_res(opc, a, b)};
        model_valid[wp] = 1'b1;
        read_pointer = wp;
        #1;
        check("word", instruction_word, model_mem[wp]);
        check("valid", IW'(read_valid), IW'(1));
    endtask

    task automatic do_op(input logic [4:0] wp, input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        accept(wp, opc, a, b);
        finish_write(wp, opc, a, b);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            read_pointer = 5'(i);
            #1;
            check({tag, "_word"}, instruction_word, model_mem[i]);
            check({tag, "_valid"}, IW'(read_valid), IW'(model_valid[i]));
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = '0;
            model_valid[i] = 1'b0;
        end
    endtask

    initial begin
        logic [3:0]  r_opc;
        logic [31:0] r_a, r_b;
        reset         = 1'b1;
        load_en       = 1'b0;
        write_pointer = '0;
        opcode        = '0;
        operand_a     = '0;
        operand_b     = '0;
        read_pointer  = '0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_ready", IW'(load_ready), IW'(1));
        check_all("reset");

        do_op(5'd3, 4'd3, -32'sd7, 32'sd5);
        do_op(5'd0, 4'd6, -32'sd15, 32'sd4);
        do_op(5'd1, 4'd7, -32'sd15, 32'sd4);
        do_op(5'd2, 4'd8, 32'sd3, 32'sd5);
        do_op(5'd4, 4'd8, -32'sd1, 32'sd3);
        do_op(5'd5, 4'd8, 32'sd2, -32'sd1);
        do_op(5'd6, 4'd6, 32'sd9, 32'sd0);
        do_op(5'd8, 4'd5, -32'sd15, 32'sd15);
        do_op(5'd9, 4'd6, 32'sd12, 32'sd3);
        do_op(5'd10, 4'd12, 32'h1234_5678, 32'h9abc_def0);
        do_op(5'd3, 4'd4, 32'sd100, -32'sd250);
        do_op(5'd11, 4'd6, 32'h8000_0000, 32'hffff_ffff);
        do_op(5'd12, 4'd7, 32'h8000_0000, 32'sd7);
        do_op(5'd13, 4'd8, 32'sd1, -32'sd4);
        do_op(5'd14, 4'd8, -32'sd1, -32'sd4);
        do_op(5'd15, 4'd8, -32'sd1, -32'sd3);
        do_op(5'd16, 4'd8, 32'sd0, 32'sd0);
        do_op(5'd17, 4'd8, 32'sd7, 32'h7fff_ffff);
        do_op(5'd18, 4'd6, 32'sd7, -32'sd2);
        do_op(5'd19, 4'd7, 32'sd7, -32'sd2);
        check_all("directed");

        // Reset lands in the 10th iteration cycle of an iterated op to entry 7.
        @(negedge clk);
        if (DIV_EN) accept(5'd7, 4'd6, 32'sd100, 32'sd7);
        else        accept(5'd7, 4'd8, 32'sd3, 32'sd1000);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        read_pointer = 5'd7;
        #1;
        check("rst_iter_ready", IW'(load_ready), IW'(1));
        check("rst_iter_word", instruction_word, '0);
        check("rst_iter_valid", IW'(read_valid), IW'(0));
        @(negedge clk);
        accept(5'd20, 4'd3, 32'sd40, 32'sd2);
        finish_write(5'd20, 4'd3, 32'sd40, 32'sd2);
        check_all("after_reset");

        for (int n = 0; n < 60; n++) begin
            r_opc = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            if ($urandom_range(0, 1) == 0) begin
                r_a = 32'($signed(32'($urandom_range(0, 40))) - 20);
                r_b = 32'($signed(32'($urandom_range(0, 40))) - 20);
            end else begin
                r_a = $urandom;
                r_b = $urandom;
            end
            do_op(5'($urandom), r_opc, r_a, r_b);
        end
        check_all("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
